// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter sharing one 8N1 UART transmit line among
// NUM_REQ requesters. A grant happens only from IDLE; the granted byte is
// captured into a shift register and sent start / data LSB-first / stop, with
// every line level lasting one baud_tick interval.
module uart_tx_arb #(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = 8,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      baud_tick,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [IDX_W-1:0]          owner,
  output logic                      busy,
  output logic                      tx
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_STOP  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                tx_q, tx_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic                busy_q, busy_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    last_q, last_d;

  logic                arb_hit_s;
  logic [IDX_W-1:0]    arb_idx_s;

  // Round-robin pick: first active request searching last+1, last+2, ... with wrap.
  always_comb begin
    int cand;
    arb_hit_s = 1'b0;
    arb_idx_s = '0;
    cand      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_q) + k) % NUM_REQ;
      if (!arb_hit_s && req[IDX_W'(cand)]) begin
        arb_hit_s = 1'b1;
        arb_idx_s = IDX_W'(cand);
      end else begin
        arb_hit_s = arb_hit_s;
      end
    end
  end

  // Next-state and output logic of the frame sequencer; gnt is a one-clock pulse.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    gnt_d     = '0;
    busy_d    = busy_q;
    owner_d   = owner_q;
    last_d    = last_q;
    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (arb_hit_s) begin
          shift_d   = data[arb_idx_s*DATA_W +: DATA_W];
          owner_d   = arb_idx_s;
          last_d    = arb_idx_s;
          gnt_d     = {{(NUM_REQ-1){1'b0}}, 1'b1} << arb_idx_s;
          busy_d    = 1'b1;
          state_d   = S_ALIGN;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_ALIGN: begin
        // A tick coinciding with the grant edge was seen in IDLE and is ignored.
        if (baud_tick) begin
          tx_d    = 1'b0;
          state_d = S_START;
        end else begin
          state_d = S_ALIGN;
        end
      end
      S_START: begin
        if (baud_tick) begin
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
          state_d   = S_DATA;
        end else begin
          state_d   = S_START;
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_STOP: begin
        if (baud_tick) begin
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_STOP;
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any frame and restarts the rr pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      owner_q   <= '0;
      last_q    <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
    end
  end

  assign gnt   = gnt_q;
  assign owner = owner_q;
  assign busy  = busy_q;
  assign tx    = tx_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: a queue-based line model predicts tx,
// gnt, owner and busy every cycle; directed literal checks pin the model.
module tb_uart_tx_arb;
  localparam int N = 4;
  localparam int W = 8;
  localparam int P = 6;

  logic           clk = 1'b0;
  logic           rst;
  logic           baud_tick;
  logic [N-1:0]   req;
  logic [N*W-1:0] data;
  logic [N-1:0]   gnt;
  logic [1:0]     owner;
  logic           busy;
  logic           tx;

  uart_tx_arb #(.NUM_REQ(N), .DATA_W(W)) dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .req(req), .data(data),
    .gnt(gnt), .owner(owner), .busy(busy), .tx(tx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: line levels still to be emitted for the current frame, one per tick.
  logic       m_tx;
  logic [N-1:0] m_gnt;
  logic [1:0] m_owner;
  logic       m_busy;
  int         m_last;
  bit         m_q[$];

  int  phase = 0;
  bit  rand_tick = 1'b0;
  int  gq[$];

  task automatic model_reset();
    m_tx = 1'b1; m_gnt = '0; m_owner = 2'd0; m_busy = 1'b0; m_last = N - 1;
    m_q.delete();
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic [N*W-1:0] d, input logic t);
    int g;
    m_gnt = '0;
    if (!m_busy) begin
      if (r != '0) begin
        g = -1;
        for (int k = 1; k <= N; k++)
          if (g < 0 && r[(m_last + k) % N]) g = (m_last + k) % N;
        m_gnt[g] = 1'b1;
        m_owner  = 2'(g);
        m_last   = g;
        m_busy   = 1'b1;
        m_q.delete();
        m_q.push_back(1'b0);
        for (int b = 0; b < W; b++) m_q.push_back(d[g*W + b]);
        m_q.push_back(1'b1);
      end
    end else if (t) begin
      if (m_q.size() > 0) m_tx = m_q.pop_front();
      else m_busy = 1'b0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("tx", 32'(tx), 32'(m_tx));
    chk("gnt", 32'(gnt), 32'(m_gnt));
    chk("owner", 32'(owner), 32'(m_owner));
    chk("busy", 32'(busy), 32'(m_busy));
  endtask

  // One clock: drive tick, advance model at the edge, compare at the falling edge.
  task automatic cyc();
    if (rand_tick) baud_tick = ($urandom_range(0, 3) == 0);
    else begin
      baud_tick = (phase == P - 1);
      phase = (phase + 1) % P;
    end
    @(posedge clk);
    if (rst) model_reset();
    else model_step(req, data, baud_tick);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    model_reset();
    check_all();
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic run(input int max_cyc, input int want, input bit reraise);
    logic [N-1:0] dropped;
    dropped = '0;
    for (int c = 0; c < max_cyc && gq.size() < want; c++) begin
      cyc();
      for (int i = 0; i < N; i++)
        if (gnt[i]) begin
          gq.push_back(i);
          req[i] = 1'b0;
          dropped[i] = 1'b1;
        end
      if (reraise && !busy && dropped != '0) begin
        req = req | dropped;
        dropped = '0;
      end
    end
    chk("run_grants", 32'(gq.size() >= want), 32'd1);
  endtask

  task automatic drain();
    for (int c = 0; c < 600 && busy; c++) cyc();
    chk("drain_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    int nt;
    int lat;
    int n0;
    logic [9:0] seq;

    rst = 1'b1; req = '0; data = '0; baud_tick = 1'b0;
    model_reset();
    @(negedge clk);
    check_all();
    cyc();
    rst = 1'b0;

    // Single frame of 8'hA5 from requester 0.
    phase = 0;
    req = 4'b0001;
    data[7:0] = 8'hA5;
    cyc();
    chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_owner", 32'(owner), 32'd0);
    req = '0;
    nt = 0; seq = '0;
    for (int c = 0; c < 400 && busy; c++) begin
      cyc();
      if (baud_tick) begin
        if (nt < 10) seq[nt] = tx;
        nt++;
      end
    end
    chk("t1_seq", 32'(seq), 32'(10'b1101001010));
    chk("t1_ticks", 32'(nt), 32'd11);
    chk("t1_busy_end", 32'(busy), 32'd0);

    // All four requesting, re-raising after each frame: order 0,1,2,3,0.
    do_reset();
    data = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'b1111;
    gq.delete();
    run(3000, 5, 1'b1);
    req = '0;
    drain();
    chk("t2_n", 32'(gq.size()), 32'd5);
    if (gq.size() == 5) begin
      chk("t2_g0", 32'(gq[0]), 32'd0);
      chk("t2_g1", 32'(gq[1]), 32'd1);
      chk("t2_g2", 32'(gq[2]), 32'd2);
      chk("t2_g3", 32'(gq[3]), 32'd3);
      chk("t2_g4", 32'(gq[4]), 32'd0);
    end

    // last=1, then 2 and 1 both pending: 2 wins, then 1.
    do_reset();
    data = {8'h0F, 8'hC3, 8'h96, 8'h00};
    gq.delete();
    req = 4'b0010;
    run(50, 1, 1'b0);
    cyc(); cyc(); cyc();
    req[2] = 1'b1;
    for (int c = 0; c < 600 && busy; c++) cyc();
    req[1] = 1'b1;
    run(3000, 3, 1'b0);
    drain();
    if (gq.size() == 3) begin
      chk("t3_g0", 32'(gq[0]), 32'd1);
      chk("t3_g1", 32'(gq[1]), 32'd2);
      chk("t3_g2", 32'(gq[2]), 32'd1);
    end else chk("t3_n", 32'(gq.size()), 32'd3);

    // Tick in the grant cycle is ignored: start bit a full interval later.
    phase = P - 1;
    req = 4'b1000;
    data[31:24] = 8'h3C;
    cyc();
    chk("t4_gnt", 32'(gnt), 32'h8);
    req = '0;
    lat = 0;
    for (int c = 0; c < 50 && tx; c++) begin
      cyc();
      lat++;
    end
    chk("t4_latency", 32'(lat), 32'(P));
    drain();

    // Reset while DATA bit 3 is on the line, then a clean frame from requester 3.
    phase = 0;
    gq.delete();
    req = 4'b0010;
    data[15:8] = 8'h5C;
    run(50, 1, 1'b0);
    nt = 0;
    for (int c = 0; c < 200 && nt < 5; c++) begin
      cyc();
      if (baud_tick) nt++;
    end
    chk("t5_bit3", 32'(tx), 32'(1'b1));
    cyc();
    do_reset();
    req = 4'b1000;
    data[31:24] = 8'hE7;
    run(50, 2, 1'b0);
    chk("t5_owner", 32'(owner), 32'd3);
    drain();

    // A request pulsed while busy and dropped before IDLE is never granted.
    gq.delete();
    req = 4'b0001;
    data[7:0] = 8'h81;
    run(50, 1, 1'b0);
    cyc(); cyc(); cyc(); cyc();
    req[2] = 1'b1;
    cyc();
    req[2] = 1'b0;
    drain();
    n0 = gq.size();
    for (int c = 0; c < 20; c++) cyc();
    chk("t6_grants", 32'(n0), 32'd1);
    chk("t6_tx", 32'(tx), 32'd1);
    chk("t6_busy", 32'(busy), 32'd0);

    // Randomized clients and ticks.
    rand_tick = 1'b1;
    for (int c = 0; c < 5000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i]) begin
          data[i*W +: W] = 8'($urandom);
          if ($urandom_range(0, 15) == 0) req[i] = 1'b1;
        end else if ($urandom_range(0, 299) == 0) req[i] = 1'b0;
      end
      cyc();
      for (int i = 0; i < N; i++)
        if (gnt[i]) begin
          req[i] = 1'b0;
          data[i*W +: W] = 8'($urandom);
        end
    end
    req = '0;
    drain();
    rand_tick = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Round-robin arbiter and frame sequencer that shares one UART transmit line among NUM_REQ requesters.
- Sits between client logic and the baud generator. Consumes the 1-cycle baud tick, grants one requester at a time, and shifts out 8N1 frames (start, DATA_W bits LSB first, stop) on a single tx output.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 8, data bits per frame
- IDX_W, $clog2(NUM_REQ), width of the owner index (derived, do not override)

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- baud_tick  input  1  one-clk pulse per bit period, from the baud generator tx tick
- req  input  NUM_REQ  per-requester transmit request; held high until gnt
- data  input  NUM_REQ*DATA_W  per-requester byte; slice i = data[i*DATA_W +: DATA_W]
- gnt  output  NUM_REQ  one-hot, one-clk acceptance pulse
- owner  output  IDX_W  index of current or last granted requester
- busy  output  1  high from grant until the end of the stop bit
- tx  output  1  serial line, idles high

Behaviour:
- One clock: clk. Reset: rst, asynchronous, active-high.
- Reset values: tx=1, gnt=0, busy=0, owner=0, state=IDLE, bit_cnt=0, shift register=0, rr pointer last=NUM_REQ-1, so requester 0 has first priority.
- States: IDLE, ALIGN, START, DATA, STOP.
- IDLE, no req: stay in IDLE, tx=1, busy=0.
- IDLE, req != 0, arbitration:
  - Select the first set bit searching last+1, last+2, ... with wrap modulo NUM_REQ.
  - On that edge: capture data slice into the shift register, set owner=idx, last=idx, gnt[idx]=1, busy=1, go to ALIGN.
- gnt lasts exactly one clk; all gnt bits are 0 in every other cycle.
- Arbitration happens only in IDLE. A req still high in the cycle after gnt is treated as a new request for a later frame.
- ALIGN: wait for baud_tick. On tick: tx<=0 (start bit), go to START. A baud_tick in the IDLE grant cycle is ignored.
- START: on baud_tick, tx<=shift[0], shift right, bit_cnt<=0, go to DATA.
- DATA: on baud_tick:
  - If bit_cnt==DATA_W-1: tx<=1 (stop bit), go to STOP.
  - Else: tx<=shift[0], shift right, bit_cnt++.
- STOP: on baud_tick, go to IDLE, busy<=0, tx stays 1.
- Line timing:
  - Each line level lasts exactly one tick interval.
  - tx changes only on the clk edge where baud_tick=1 (except reset).
  - Frame = 1 + DATA_W + 1 bit periods.
- Back-to-back frames: IDLE lasts at least 1 clk, then ALIGN waits for the next tick. Inter-frame idle line is therefore about one extra bit period (effective 2 stop bits).
- Grant-to-start latency: 1 clk for gnt, plus wait to the next tick.
- Requests that drop before grant are never served; no request is latched without gnt.
- req, data and baud_tick are synchronous to clk; no synchronizers inside.
- Reset mid-frame: outputs return to reset values immediately, the frame is aborted, and the rr pointer resets.
- owner holds its value after the frame ends until the next grant.

Test Plan:
- Reset, then req=0001, data[0]=8'hA5 → gnt=0001 for 1 clk, owner=0. tx sequence per tick: 0, 1,0,1,0,0,1,0,1, 1. busy falls on the stop-end tick.
- req=1111 held continuously, each requester drops req the clk after its gnt and re-raises it after busy falls → grant order 0,1,2,3,0; each frame carries the correct byte.
- req=0100 while frame 1 in flight, then req=0110 after busy falls, last=1 → next grant goes to 2, then 1 (rr search starts at last+1).
- baud_tick coincident with the grant cycle → ignored; start bit begins on the following tick. Line is high for ≥1 full tick interval between frames.
- Assert rst during DATA bit 3 → tx=1, busy=0, gnt=0 asynchronously. After release, req=1000 → owner=3 and a full clean frame is sent.
- Pulse req[2] for 1 clk while busy, deasserted before IDLE → no gnt, tx stays high, busy=0.
